// File: rtl/memory_access_module.sv
// Memory stage: passes ALU results through, or runs scalar/vector (1 or 4 beat)
// word loads and stores on a single-cycle-latency memory port. Optional MEM_STALL_CNT_EN.
module memory_access_module (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         MemRead1,
  input  logic         MemWrite1,
  input  logic         RegWrite1,
  input  logic         VF1,
  input  logic [3:0]   R_V_dest1,
  input  logic [127:0] ALURES1,
  input  logic [127:0] StoreData1,
  output logic         stall,
  output logic [31:0]  mem_addr,
  output logic         mem_re,
  output logic         mem_we,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  output logic         out_valid,
  output logic         RegWrite2,
  output logic         VF2,
  output logic [3:0]   R_V_dest2,
  output logic [127:0] ALURES2,
  output logic [31:0]  stall_count
);

  typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_t;

  state_t         r_state;
  logic [1:0]     r_beat;
  logic [1:0]     r_last_beat;
  logic           r_regwrite;
  logic           r_vf;
  logic [3:0]     r_dest;
  logic [2:0][31:0] r_store_hi;  // store lanes 1..3; lane 0 goes out directly at acceptance
  logic [2:0][31:0] r_load_buf;  // load lanes 0..2; the last lane comes straight from mem_rdata

  logic [31:0]    r_mem_addr;
  logic           r_mem_re;
  logic           r_mem_we;
  logic [31:0]    r_mem_wdata;
  logic           r_out_valid;
  logic           r_regwrite2;
  logic           r_vf2;
  logic [3:0]     r_dest2;
  logic [127:0]   r_alures2;

  logic           w_mem_op;
  logic           w_accept_mem;

  assign w_mem_op     = in_valid & (MemRead1 | MemWrite1);
  assign w_accept_mem = (r_state == IDLE) & w_mem_op;

  // Stall must reach upstream in the acceptance cycle itself, so it is combinational.
  assign stall = ~rst & ((r_state != IDLE) | w_accept_mem);

  // NOTE: the lane buffers carry no reset; every lane is written before it is read.
  always_ff @(posedge clk) begin
    if (w_accept_mem) begin
      r_store_hi <= StoreData1[127:32];
    end
    if (r_state == RD && r_beat != 2'd0) begin
      r_load_buf[r_beat - 2'd1] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_regwrite  <= 1'b0;
      r_vf        <= 1'b0;
      r_dest      <= '0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_out_valid <= 1'b0;
      r_regwrite2 <= 1'b0;
      r_vf2       <= 1'b0;
      r_dest2     <= '0;
      r_alures2   <= '0;
    end else begin
      // NOTE: this default makes out_valid a one-cycle pulse; later assignments win.
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && (MemRead1 || MemWrite1)) begin
            r_regwrite  <= RegWrite1;
            r_vf        <= VF1;
            r_dest      <= R_V_dest1;
            r_beat      <= 2'd0;
            r_last_beat <= VF1 ? 2'd3 : 2'd0;
            r_mem_addr  <= {ALURES1[31:2], 2'b00};
            // A combined read+write request is a store.
            if (MemWrite1) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= StoreData1[31:0];
              r_state     <= WR;
            end else begin
              r_mem_re <= 1'b1;
              r_state  <= RD;
            end
          end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_regwrite2 <= RegWrite1;
            r_vf2       <= VF1;
            r_dest2     <= R_V_dest1;
            r_alures2   <= ALURES1;
          end
        end

        RD: begin
          if (r_beat == r_last_beat) begin
            r_mem_re <= 1'b0;
            r_state  <= RD_DRAIN;
          end else begin
            r_beat     <= r_beat + 2'd1;
            r_mem_addr <= r_mem_addr + 32'd4;
          end
        end

        RD_DRAIN: begin
          r_alures2   <= r_vf ? {mem_rdata, r_load_buf[2], r_load_buf[1], r_load_buf[0]}
                              : {96'd0, mem_rdata};
          r_out_valid <= 1'b1;
          r_regwrite2 <= r_regwrite;
          r_vf2       <= r_vf;
          r_dest2     <= r_dest;
          r_state     <= IDLE;
        end

        WR: begin
          if (r_beat == r_last_beat) begin
            // ALURES2 keeps its last value: RegWrite2=0 means nobody forwards it.
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b1;
            r_regwrite2 <= 1'b0;
            r_vf2       <= r_vf;
            r_dest2     <= r_dest;
            r_state     <= IDLE;
          end else begin
            r_beat      <= r_beat + 2'd1;
            r_mem_addr  <= r_mem_addr + 32'd4;
            r_mem_wdata <= r_store_hi[r_beat];
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign RegWrite2 = r_regwrite2;
  assign VF2       = r_vf2;
  assign R_V_dest2 = r_dest2;
  assign ALURES2   = r_alures2;

endmodule

// File: tb/tb_memory_access_module.sv
// Bench for memory_access_module: directed literal cases plus random instruction
// stream checked every cycle against a transaction-level expectation table.
`timescale 1ns/1ps
module tb_memory_access_module;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         MemRead1 = 1'b0;
  logic         MemWrite1 = 1'b0;
  logic         RegWrite1 = 1'b0;
  logic         VF1 = 1'b0;
  logic [3:0]   R_V_dest1 = '0;
  logic [127:0] ALURES1 = '0;
  logic [127:0] StoreData1 = '0;
  logic [31:0]  mem_rdata = '0;
  logic         stall;
  logic [31:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic         out_valid;
  logic         RegWrite2;
  logic         VF2;
  logic [3:0]   R_V_dest2;
  logic [127:0] ALURES2;
  logic [31:0]  stall_count;

  memory_access_module dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead1(MemRead1),
    .MemWrite1(MemWrite1), .RegWrite1(RegWrite1), .VF1(VF1),
    .R_V_dest1(R_V_dest1), .ALURES1(ALURES1), .StoreData1(StoreData1),
    .stall(stall), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .RegWrite2(RegWrite2), .VF2(VF2), .R_V_dest2(R_V_dest2),
    .ALURES2(ALURES2), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           iv, mr, mw, rw, vf;
    logic [3:0]   dest;
    logic [127:0] alu, sd;
  } instr_t;

  typedef struct {
    bit           rw, vf, chk_res;
    logic [3:0]   dest;
    logic [127:0] res;
  } ov_t;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int free_cyc = 0;
  bit prev_re = 1'b0;
  logic [31:0] prev_addr = '0;

  // Expected per-cycle activity, keyed by cycle number.
  bit          exp_stall[int];
  logic [31:0] exp_re[int];
  logic [63:0] exp_we[int];
  ov_t         exp_ov[int];

  instr_t idle_i = '{default: '0};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory contents: words 1..4 at 0x100..0x10C, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h10C) return ((a - 32'h100) >> 2) + 32'd1;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic instr_t mk(input bit mr, mw, rw, vf, input logic [3:0] d,
                                input logic [127:0] alu, sd);
    instr_t i;
    i.iv = 1'b1; i.mr = mr; i.mw = mw; i.rw = rw; i.vf = vf;
    i.dest = d; i.alu = alu; i.sd = sd;
    return i;
  endfunction

  task automatic model_step();
    int n;
    logic [31:0] base;
    logic [127:0] r;
    ov_t o;
    if (rst) begin
      exp_stall.delete(); exp_re.delete(); exp_we.delete(); exp_ov.delete();
      free_cyc = cyc + 1;
      return;
    end
    if (cyc < free_cyc) return;
    if (!in_valid) begin
      free_cyc = cyc + 1;
      return;
    end
    o.vf = VF1; o.dest = R_V_dest1;
    if (MemRead1 || MemWrite1) begin
      n = VF1 ? 4 : 1;
      base = {ALURES1[31:2], 2'b00};
      if (MemWrite1) begin
        for (int k = 0; k < n; k++)
          exp_we[cyc + 1 + k] = {base + 32'(4 * k), StoreData1[32 * k +: 32]};
        for (int j = 0; j <= n; j++) exp_stall[cyc + j] = 1'b1;
        o.rw = 1'b0; o.chk_res = 1'b0; o.res = '0;
        exp_ov[cyc + n + 1] = o;
        free_cyc = cyc + n + 1;
      end else begin
        r = '0;
        for (int k = 0; k < n; k++) begin
          exp_re[cyc + 1 + k] = base + 32'(4 * k);
          r[32 * k +: 32] = mem_word(base + 32'(4 * k));
        end
        for (int j = 0; j <= n + 1; j++) exp_stall[cyc + j] = 1'b1;
        o.rw = RegWrite1; o.chk_res = 1'b1; o.res = r;
        exp_ov[cyc + n + 2] = o;
        free_cyc = cyc + n + 2;
      end
    end else begin
      o.rw = RegWrite1; o.chk_res = 1'b1; o.res = ALURES1;
      exp_ov[cyc + 1] = o;
      free_cyc = cyc + 1;
    end
  endtask

  // One clock cycle: memory responds, new inputs only when upstream is not stalled.
  task automatic cyc_step(input instr_t ins, input bit do_rst);
    @(negedge clk);
    cyc++;
    mem_rdata = prev_re ? mem_word(prev_addr) : $urandom;
    rst = do_rst;
    if (cyc >= free_cyc) begin
      in_valid = ins.iv; MemRead1 = ins.mr; MemWrite1 = ins.mw;
      RegWrite1 = ins.rw; VF1 = ins.vf; R_V_dest1 = ins.dest;
      ALURES1 = ins.alu; StoreData1 = ins.sd;
    end
    model_step();
  endtask

  task automatic finish_instr();
    int f;
    f = free_cyc;
    while (cyc < f) cyc_step(idle_i, 1'b0);
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    logic [31:0] a;
    int op;
    op = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0:       a = 32'h100 + 32'($urandom_range(0, 3));
      1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: a = $urandom;
    endcase
    i.iv = (op >= 2);
    i.mr = (op >= 5 && op <= 7) ? 1'b1 : (op >= 8 || op < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    i.mw = (op >= 8) ? 1'b1 : (op < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    i.rw = 1'($urandom_range(0, 1));
    i.vf = 1'($urandom_range(0, 1));
    i.dest = 4'($urandom_range(0, 15));
    i.alu = {$urandom, $urandom, $urandom, a};
    i.sd = {$urandom, $urandom, $urandom, $urandom};
    return i;
  endfunction

  // Per-cycle comparison against the expectation table.
  initial begin
    int cnt = 0;
    bit zero_next = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        zero_next = 1'b1;
      end else begin
        if (zero_next) begin
          check("rst_mem_re", mem_re, 0);
          check("rst_mem_we", mem_we, 0);
          check("rst_mem_addr", mem_addr, 0);
          check("rst_mem_wdata", mem_wdata, 0);
          check("rst_out_valid", out_valid, 0);
          check("rst_regwrite2", RegWrite2, 0);
          check("rst_vf2", VF2, 0);
          check("rst_dest2", R_V_dest2, 0);
          check("rst_alures2", ALURES2, 0);
          check("rst_stall_count", stall_count, 0);
          zero_next = 1'b0;
        end
        check("stall", stall, exp_stall.exists(cyc));
        check("mem_re", mem_re, exp_re.exists(cyc));
        if (exp_re.exists(cyc)) check("rd_addr", mem_addr, exp_re[cyc]);
        check("mem_we", mem_we, exp_we.exists(cyc));
        if (exp_we.exists(cyc)) begin
          check("wr_addr", mem_addr, exp_we[cyc][63:32]);
          check("wr_data", mem_wdata, exp_we[cyc][31:0]);
        end
        check("out_valid", out_valid, exp_ov.exists(cyc));
        if (exp_ov.exists(cyc)) begin
          check("regwrite2", RegWrite2, exp_ov[cyc].rw);
          check("vf2", VF2, exp_ov[cyc].vf);
          check("dest2", R_V_dest2, exp_ov[cyc].dest);
          if (exp_ov[cyc].chk_res) check("alures2", ALURES2, exp_ov[cyc].res);
        end
`ifdef MEM_STALL_CNT_EN
        check("stall_count", stall_count, cnt);
        if (exp_stall.exists(cyc)) cnt++;
`else
        check("stall_count", stall_count, 0);
`endif
      end
      prev_re = mem_re;
      prev_addr = mem_addr;
    end
  end

  initial begin
    logic [31:0] vs_addr [4];
    vs_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    cyc_step(idle_i, 1'b1);
    cyc_step(idle_i, 1'b1);
    cyc_step(idle_i, 1'b0);

    // ALU pass-through
    cyc_step(mk(0, 0, 1, 0, 4'd4, 128'hA, 128'h0), 1'b0);
    cyc_step(idle_i, 1'b0);
    #2;
    check("alu_ov", out_valid, 1);
    check("alu_res", ALURES2, 128'hA);
    check("alu_dest", R_V_dest2, 4);
    check("alu_stall", stall, 0);

    // Vector load at 0x100
    cyc_step(mk(1, 0, 1, 1, 4'd7, 128'h100, 128'h0), 1'b0);
    #2 check("vld_stall_T", stall, 1);
    for (int k = 0; k < 4; k++) begin
      cyc_step(idle_i, 1'b0);
      #2;
      check("vld_re", mem_re, 1);
      check("vld_addr", mem_addr, 32'h100 + 32'(4 * k));
      check("vld_stall", stall, 1);
    end
    cyc_step(idle_i, 1'b0);
    #2;
    check("vld_drain_stall", stall, 1);
    check("vld_drain_re", mem_re, 0);
    cyc_step(idle_i, 1'b0);
    #2;
    check("vld_ov", out_valid, 1);
    check("vld_res", ALURES2, 128'h00000004_00000003_00000002_00000001);
    check("vld_stall_end", stall, 0);

    // Scalar store at 0x23
    cyc_step(mk(0, 1, 1, 0, 4'd2, 128'h23, 128'hDEAD), 1'b0);
    cyc_step(idle_i, 1'b0);
    #2;
    check("sst_we", mem_we, 1);
    check("sst_re", mem_re, 0);
    check("sst_addr", mem_addr, 32'h20);
    check("sst_data", mem_wdata, 32'h0000DEAD);
    cyc_step(idle_i, 1'b0);
    #2;
    check("sst_ov", out_valid, 1);
    check("sst_regwrite2", RegWrite2, 0);

    // Vector store across the address wrap, read+write requested together
    cyc_step(mk(1, 1, 1, 1, 4'd3, 128'hFFFF_FFF8,
                128'h44444444_33333333_22222222_11111111), 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc_step(idle_i, 1'b0);
      #2;
      check("vst_we", mem_we, 1);
      check("vst_re", mem_re, 0);
      check("vst_addr", mem_addr, vs_addr[k]);
    end
    finish_instr();

    // Stall counter over one vector load and one scalar load
    cyc_step(idle_i, 1'b1);
    cyc_step(mk(1, 0, 1, 1, 4'd1, 128'h200, 128'h0), 1'b0);
    finish_instr();
    cyc_step(mk(1, 0, 1, 0, 4'd1, 128'h204, 128'h0), 1'b0);
    finish_instr();
    #2;
`ifdef MEM_STALL_CNT_EN
    check("stall_count_9", stall_count, 9);
`else
    check("stall_count_off", stall_count, 0);
`endif

    // Reset in the middle of a vector load
    cyc_step(mk(1, 0, 1, 1, 4'd5, 128'h300, 128'h0), 1'b0);
    cyc_step(idle_i, 1'b0);
    cyc_step(idle_i, 1'b1);
    cyc_step(idle_i, 1'b0);
    #2;
    check("abort_re", mem_re, 0);
    check("abort_ov", out_valid, 0);
    check("abort_res", ALURES2, 0);
    check("abort_stall", stall, 0);

    // Random instruction stream
    for (int i = 0; i < 1500; i++) cyc_step(rand_instr(), 1'b0);
    finish_instr();
    repeat (4) cyc_step(idle_i, 1'b0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
